// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and
// the default drain length.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STALL_MEM = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_HALTED    = 3'd4
  } pipe_state_t;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction currently in ID. Purely combinational.
module hazard_detect (
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  output logic       load_use_o
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use_o = idex_memread_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule : hazard_detect

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/run controller: PC and IF/ID enables, flush, bubble and
// back-end hold. Optional stall/flush counters enabled by STALL_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       halt_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  input  logic       branch_taken_i,
  input  logic       mem_stall_i,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic       idex_bubble_o,
  output logic       hold_o,
  output logic       running_o
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  pipe_state_t state_q, state_d;
  logic [2:0]  drain_q, drain_d;
  logic        load_use;

  hazard_detect u_hazard_detect (
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .load_use_o     (load_use)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    hold_o        = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      // STALL_MEM shares the RUN evaluation so the release cycle acts as RUN.
      ST_RUN, ST_STALL_MEM: begin
        hold_o = 1'b0;
        if (mem_stall_i) begin
          hold_o  = 1'b1;
          state_d = ST_STALL_MEM;
        end else begin
          state_d = ST_RUN;
          if (load_use) begin
            idex_bubble_o = 1'b1;
          end else if (halt_i) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = branch_taken_i;
          end
        end
        if (!start_i) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        ifid_flush_o = 1'b1;
        hold_o       = mem_stall_i;
        if (!mem_stall_i) begin
          if (drain_q == '0) state_d = ST_HALTED;
          else               drain_d = drain_q - 3'd1;
        end
      end
      ST_HALTED: ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign running_o = (state_q == ST_RUN) || (state_q == ST_STALL_MEM);

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (running_o && !pc_write_o && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (running_o && ifid_flush_o && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues expected output vectors,
// a monitor compares them at the falling edge of each cycle.
module tb_pipe_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i, halt_i, idex_memread_i, branch_taken_i, mem_stall_i;
  logic [4:0] idex_rt_i, ifid_rs_i, ifid_rt_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, hold_o, running_o;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .halt_i         (halt_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .branch_taken_i (branch_taken_i),
    .mem_stall_i    (mem_stall_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .hold_o         (hold_o),
    .running_o      (running_o)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  typedef struct {
    logic [5:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, hold, running}
  localparam logic [5:0] E_IDLE   = 6'b000010;
  localparam logic [5:0] E_RUN    = 6'b110001;
  localparam logic [5:0] E_BRANCH = 6'b111001;
  localparam logic [5:0] E_LDUSE  = 6'b000101;
  localparam logic [5:0] E_MSTALL = 6'b000011;
  localparam logic [5:0] E_HALTC  = 6'b000001;
  localparam logic [5:0] E_DRAIN  = 6'b001000;
  localparam logic [5:0] E_DRSTL  = 6'b001010;

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e   = exp_q.pop_front();
      act = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, hold_o, running_o};
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b (pc,ifw,flush,bubble,hold,run)", e.name, act, e.exp);
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic step(input logic rst, input logic st, input logic ht,
                      input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                      input logic [4:0] rt, input logic br, input logic ms,
                      input logic [5:0] exp, input string nm);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = rst; start_i = st; halt_i = ht; idex_memread_i = mr;
    idex_rt_i = xrt; ifid_rs_i = rs; ifid_rt_i = rt;
    branch_taken_i = br; mem_stall_i = ms;
    e.exp = exp;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic chk32(input logic [31:0] act, input logic [31:0] exp, input string nm);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; halt_i = 1'b0; idex_memread_i = 1'b0;
    idex_rt_i = '0; ifid_rs_i = '0; ifid_rt_i = '0;
    branch_taken_i = 1'b0; mem_stall_i = 1'b0;

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "reset_idle");
`ifdef STALL_CNT_EN
    chk32(stall_cnt_o, 0, "reset_stall_cnt");
    chk32(flush_cnt_o, 0, "reset_flush_cnt");
`endif
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "idle_start");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN,    "run_first");
    step(1, 1, 0, 1, 5, 5, 0, 0, 0, E_LDUSE,  "ld_use_rs");
    step(1, 1, 0, 0, 5, 5, 0, 0, 0, E_RUN,    "ld_use_clear");
    step(1, 1, 0, 1, 0, 0, 5, 0, 0, E_RUN,    "ld_rt_zero");
    step(1, 1, 0, 1, 7, 3, 7, 0, 0, E_LDUSE,  "ld_use_rt");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, E_MSTALL, "mstall_1");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, E_MSTALL, "mstall_2");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, E_MSTALL, "mstall_3");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, E_MSTALL, "mstall_4");
    step(1, 1, 0, 0, 0, 0, 0, 1, 0, E_BRANCH, "mstall_release_br");
    step(1, 1, 0, 1, 9, 9, 0, 1, 0, E_LDUSE,  "ld_use_and_branch");
    step(1, 1, 0, 0, 9, 9, 0, 1, 0, E_BRANCH, "branch_after_ld");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,    "start_drop_run");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "back_to_idle");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "restart_idle");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN,    "restart_run");
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, E_HALTC,  "halt_issue");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_DRAIN,  "drain_1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_DRAIN,  "drain_2");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_DRAIN,  "drain_3");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "halted_1");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "halted_start");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "halted_stays");

    // Drain pause on memory stall, then run to HALTED.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "reset2");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "r2_idle");
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, E_HALTC,  "r2_halt");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_DRAIN,  "r2_drain_1");
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, E_DRSTL,  "r2_drain_paused");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_DRAIN,  "r2_drain_2");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_DRAIN,  "r2_drain_3");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "r2_halted");

    // Asynchronous reset in the middle of DRAIN.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "reset3");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "r3_idle");
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, E_HALTC,  "r3_halt");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_DRAIN,  "r3_drain");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "async_rst_drain");

    // Asynchronous reset in the middle of STALL_MEM.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "r4_idle");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, E_MSTALL, "r4_mstall_1");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, E_MSTALL, "r4_mstall_2");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, E_MSTALL, "r4_mstall_3");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, E_MSTALL, "r4_mstall_4");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN,    "r4_release");
`ifdef STALL_CNT_EN
    chk32(stall_cnt_o, 4, "stall_cnt_4");
    chk32(flush_cnt_o, 0, "flush_cnt_0");
`endif
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, E_MSTALL, "r4_mstall_again");
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, E_IDLE,   "async_rst_stall");
`ifdef STALL_CNT_EN
    chk32(stall_cnt_o, 0, "async_rst_stall_cnt");
`endif
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_IDLE,   "r5_idle");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN,    "r5_run_clean");

    for (int unsigned i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_i);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipe_ctrl
